// File: rtl/decode_pkg.sv
// Shared defaults and the ID/EX control bundle for decode_stage.
// The write-first register file is selected with DECODE_BYPASS_EN (see regfile_nr).
package decode_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;
    localparam int IMM_W_DEF  = 16;
    // dest is sized for the largest supported register file (256); narrower files zero-extend into it.
    localparam int MAX_ADDR_W = 8;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic [MAX_ADDR_W-1:0] dest;
    } idex_ctrl_t;
endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, write-back port, flush and the ID/EX output handshake.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IMM_W  = IMM_W_DEF
);
    localparam int ADDR_W = $clog2(NREG);

    logic              in_valid, in_ready;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [IMM_W-1:0]  imm;
    logic              reg_dst, reg_write, mem_read, uses_rt;
    logic              flush;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_rd_data1, out_rd_data2, out_sgn_ext_imm, out_imm_shl2;
    logic [IMM_W-1:0]  out_imm_raw;
    logic [ADDR_W-1:0] out_dest;
    logic              out_reg_write, out_mem_read;

    modport master (
        output in_valid, rs, rt, rd, imm, reg_dst, reg_write, mem_read, uses_rt,
               flush, wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_rd_data1, out_rd_data2, out_sgn_ext_imm,
               out_imm_shl2, out_imm_raw, out_dest, out_reg_write, out_mem_read
    );

    modport slave (
        input  in_valid, rs, rt, rd, imm, reg_dst, reg_write, mem_read, uses_rt,
               flush, wb_we, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_rd_data1, out_rd_data2, out_sgn_ext_imm,
               out_imm_shl2, out_imm_raw, out_dest, out_reg_write, out_mem_read
    );
endinterface

// File: rtl/regfile_nr.sv
// 2R1W register file with r0 hardwired to zero. Read-before-write by default;
// defining DECODE_BYPASS_EN makes reads write-first (same-cycle WB data is returned).
module regfile_nr #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [DATA_W-1:0]       rd1,
    output logic [DATA_W-1:0]       rd2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [DATA_W-1:0]       wd
);
    logic [DATA_W-1:0] mem [NREG];

    // NOTE: the array is reset because every architectural register must read 0 after reset;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // NOTE: outputs get their default first so every path assigns them and no latch is inferred.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
        rd2 = (ra2 == '0) ? '0 : mem[ra2];
`ifdef DECODE_BYPASS_EN
        if (we && wa != '0 && wa == ra1) rd1 = wd;
        if (we && wa != '0 && wa == ra2) rd2 = wd;
`endif
    end
endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file read, immediate extension, destination select,
// load-use interlock and the ID/EX register. DECODE_BYPASS_EN selects a write-first register file.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IMM_W  = IMM_W_DEF
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int ADDR_W = $clog2(NREG);

    logic [DATA_W-1:0] rd1, rd2, sgn_ext;
    logic [ADDR_W-1:0] dest_sel;
    logic              hazard, in_ready, accept;
    idex_ctrl_t        ctrl_d, ctrl_q;
    logic              valid_q;
    logic [DATA_W-1:0] data1_q, data2_q, sgn_q, shl2_q;
    logic [IMM_W-1:0]  imm_q;

    regfile_nr #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk (clk),
        .reset (reset),
        .ra1 (bus.rs),
        .ra2 (bus.rt),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (bus.wb_we),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

    // A load still in ID/EX whose target is read now must be let through one cycle before this instruction.
    always_comb begin
        hazard   = valid_q && ctrl_q.mem_read && ctrl_q.reg_write && (ctrl_q.dest != '0)
                && ((ctrl_q.dest == MAX_ADDR_W'(bus.rs))
                    || (bus.uses_rt && (ctrl_q.dest == MAX_ADDR_W'(bus.rt))));
        in_ready = !hazard && (!valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        dest_sel         = bus.reg_dst ? bus.rd : bus.rt;
        ctrl_d.reg_write = bus.reg_write;
        ctrl_d.mem_read  = bus.mem_read;
        ctrl_d.dest      = MAX_ADDR_W'(dest_sel);

        sgn_ext = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            sgn_q   <= '0;
            shl2_q  <= '0;
            imm_q   <= '0;
        end else begin
            if (bus.flush)          valid_q <= 1'b0;
            else if (accept)        valid_q <= 1'b1;
            else if (bus.out_ready) valid_q <= 1'b0;

            // A flushed accept is dropped entirely; otherwise fields only move on accept.
            if (accept && !bus.flush) begin
                ctrl_q  <= ctrl_d;
                data1_q <= rd1;
                data2_q <= rd2;
                sgn_q   <= sgn_ext;
                shl2_q  <= sgn_ext << 2;
                imm_q   <= bus.imm;
            end
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = valid_q;
    assign bus.out_rd_data1    = data1_q;
    assign bus.out_rd_data2    = data2_q;
    assign bus.out_sgn_ext_imm = sgn_q;
    assign bus.out_imm_shl2    = shl2_q;
    assign bus.out_imm_raw     = imm_q;
    assign bus.out_dest        = ctrl_q.dest[ADDR_W-1:0];
    assign bus.out_reg_write   = ctrl_q.reg_write;
    assign bus.out_mem_read    = ctrl_q.mem_read;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default widths); expectations follow DECODE_BYPASS_EN.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_stage_if bus ();

    decode_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.imm = '0;
        bus.reg_dst = 1'b0; bus.reg_write = 1'b0; bus.mem_read = 1'b0; bus.uses_rt = 1'b0;
        bus.flush = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic reg_dst, input logic [15:0] imm, input logic reg_write,
                             input logic mem_read, input logic uses_rt);
        bus.in_valid = 1'b1; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.reg_dst = reg_dst;
        bus.imm = imm; bus.reg_write = reg_write; bus.mem_read = mem_read; bus.uses_rt = uses_rt;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        bus.wb_we = we; bus.wb_addr = addr; bus.wb_data = data;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %h want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %h want 1", bus.in_ready); end
        n_checks++; if (bus.out_rd_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data1: got %h want 0", bus.out_rd_data1); end
        n_checks++; if (bus.out_sgn_ext_imm !== 32'h0) begin n_fail++; $display("FAIL reset_sgn_imm: got %h want 0", bus.out_sgn_ext_imm); end
        n_checks++; if (bus.out_dest !== 5'd0) begin n_fail++; $display("FAIL reset_dest: got %0d want 0", bus.out_dest); end
    endtask

    task automatic test_wb_decode();
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        set_instr(5'd5, 5'd0, 5'd9, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wb_in_ready: got %h want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wb_out_valid: got %h want 1", bus.out_valid); end
        n_checks++; if (bus.out_rd_data1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_data1: got %h want deadbeef", bus.out_rd_data1); end
        n_checks++; if (bus.out_rd_data2 !== 32'h0) begin n_fail++; $display("FAIL wb_data2: got %h want 0", bus.out_rd_data2); end
        n_checks++; if (bus.out_dest !== 5'd9) begin n_fail++; $display("FAIL wb_dest: got %0d want 9", bus.out_dest); end
        n_checks++; if (bus.out_reg_write !== 1'b1) begin n_fail++; $display("FAIL wb_reg_write: got %h want 1", bus.out_reg_write); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wb_drain: got %h want 0", bus.out_valid); end
    endtask

    task automatic test_imm();
        set_instr(5'd0, 5'd4, 5'd0, 1'b0, 16'h8004, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (bus.out_sgn_ext_imm !== 32'hFFFF8004) begin n_fail++; $display("FAIL imm_neg_sext: got %h want ffff8004", bus.out_sgn_ext_imm); end
        n_checks++; if (bus.out_imm_shl2 !== 32'hFFFE0010) begin n_fail++; $display("FAIL imm_neg_shl2: got %h want fffe0010", bus.out_imm_shl2); end
        n_checks++; if (bus.out_imm_raw !== 16'h8004) begin n_fail++; $display("FAIL imm_neg_raw: got %h want 8004", bus.out_imm_raw); end
        n_checks++; if (bus.out_dest !== 5'd4) begin n_fail++; $display("FAIL imm_dest_rt: got %0d want 4", bus.out_dest); end
        bus.imm = 16'h7FFF;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_sgn_ext_imm !== 32'h00007FFF) begin n_fail++; $display("FAIL imm_pos_sext: got %h want 00007fff", bus.out_sgn_ext_imm); end
        n_checks++; if (bus.out_imm_shl2 !== 32'h0001FFFC) begin n_fail++; $display("FAIL imm_pos_shl2: got %h want 0001fffc", bus.out_imm_shl2); end
        tick();
    endtask

    task automatic test_hazard();
        set_instr(5'd0, 5'd3, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (bus.out_mem_read !== 1'b1) begin n_fail++; $display("FAIL hz_load_captured: got %h want 1", bus.out_mem_read); end
        set_instr(5'd3, 5'd0, 5'd4, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_stall: got %h want 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hz_bubble: got %h want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_release: got %h want 1", bus.in_ready); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_dest !== 5'd4) begin n_fail++; $display("FAIL hz_after_bubble: got valid %h dest %0d want 1/4", bus.out_valid, bus.out_dest); end
        // rt matches the load target but is not read: no stall unless uses_rt is set
        set_instr(5'd0, 5'd3, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        tick();
        set_instr(5'd0, 5'd3, 5'd6, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_rt_unused: got %h want 1", bus.in_ready); end
        bus.uses_rt = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_rt_used: got %h want 0", bus.in_ready); end
        bus.uses_rt = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_dest !== 5'd6) begin n_fail++; $display("FAIL hz_no_bubble: got valid %h dest %0d want 1/6", bus.out_valid, bus.out_dest); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_r7;
`ifdef DECODE_BYPASS_EN
        exp_r7 = 32'h12345678;
`else
        exp_r7 = 32'h11111111;
`endif
        wb(1'b1, 5'd7, 32'h11111111);
        tick();
        wb(1'b1, 5'd7, 32'h12345678);
        set_instr(5'd7, 5'd0, 5'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        n_checks++; if (bus.out_rd_data1 !== exp_r7) begin n_fail++; $display("FAIL byp_same_cycle: got %h want %h", bus.out_rd_data1, exp_r7); end
        tick();
        n_checks++; if (bus.out_rd_data1 !== 32'h12345678) begin n_fail++; $display("FAIL byp_after_write: got %h want 12345678", bus.out_rd_data1); end
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        set_instr(5'd0, 5'd0, 5'd1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        n_checks++; if (bus.out_rd_data1 !== 32'h0 || bus.out_rd_data2 !== 32'h0) begin n_fail++; $display("FAIL r0_same_cycle: got %h/%h want 0/0", bus.out_rd_data1, bus.out_rd_data2); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_rd_data1 !== 32'h0) begin n_fail++; $display("FAIL r0_later: got %h want 0", bus.out_rd_data1); end
        tick();
    endtask

    task automatic test_stall_flush();
        bus.out_ready = 1'b0;
        set_instr(5'd5, 5'd7, 5'd2, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_data2 !== 32'h12345678) begin n_fail++; $display("FAIL st_capture: got valid %h data2 %h want 1/12345678", bus.out_valid, bus.out_rd_data2); end
        set_instr(5'd5, 5'd0, 5'd3, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
        wb(1'b1, 5'd5, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL st_in_ready[%0d]: got %h want 0", i, bus.in_ready); end
            tick();
            wb(1'b0, 5'd0, 32'h0);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_data1 !== 32'hDEADBEEF || bus.out_dest !== 5'd2 || bus.out_imm_raw !== 16'h0010)
                begin n_fail++; $display("FAIL st_hold[%0d]: got valid %h data1 %h dest %0d imm %h want 1/deadbeef/2/0010", i, bus.out_valid, bus.out_rd_data1, bus.out_dest, bus.out_imm_raw); end
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_kill: got %h want 0", bus.out_valid); end
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %h want 1", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_over_accept: got %h want 0", bus.out_valid); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_data1 !== 32'hCAFEF00D || bus.out_dest !== 5'd3)
            begin n_fail++; $display("FAIL fl_reaccept: got valid %h data1 %h dest %0d want 1/cafef00d/3", bus.out_valid, bus.out_rd_data1, bus.out_dest); end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_rd_data1 !== 32'h0 || bus.out_dest !== 5'd0 || bus.out_reg_write !== 1'b0)
            begin n_fail++; $display("FAIL rm_async: got valid %h data1 %h dest %0d rw %h want all 0", bus.out_valid, bus.out_rd_data1, bus.out_dest, bus.out_reg_write); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %h want 1", bus.in_ready); end
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        set_instr(5'd5, 5'd7, 5'd2, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_rd_data1 !== 32'h0 || bus.out_rd_data2 !== 32'h0) begin n_fail++; $display("FAIL rm_rf_cleared: got %h/%h want 0/0", bus.out_rd_data1, bus.out_rd_data2); end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_wb_decode();
        test_imm();
        test_hazard();
        test_bypass();
        test_stall_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode pipeline stage. It holds an N-entry register file, sign-extends and shifts the immediate, and selects the destination register. Results are registered into an ID/EX output register with a valid/ready handshake, and a load-use interlock inserts bubbles. The stage sits between the fetch/IF-ID register and the execute stage, and receives write-back traffic from the WB stage.

## Interface
- DATA_W, 32, register and datapath width
- NREG, 32, number of architectural registers (power of two, ≥2); ADDR_W = $clog2(NREG)
- IMM_W, 16, immediate field width (IMM_W < DATA_W)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode inputs valid
- in_ready  out  1  stage accepts inputs this cycle
- rs, rt, rd  in  ADDR_W each  source 1, source 2, R-type destination
- imm  in  IMM_W  raw immediate
- reg_dst  in  1  0: dest=rt, 1: dest=rd
- reg_write, mem_read, uses_rt  in  1 each  control bits; uses_rt=1 when rt is a read operand
- flush  in  1  kill the contents of the output register
- wb_we  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- out_valid  out  1  ID/EX contents valid
- out_ready  in  1  execute stage consumes ID/EX
- out_rd_data1, out_rd_data2  out  DATA_W  operands
- out_sgn_ext_imm, out_imm_shl2  out  DATA_W  sign-extended immediate and its value shifted left by 2
- out_imm_raw  out  IMM_W  unextended immediate
- out_dest  out  ADDR_W  selected destination
- out_reg_write, out_mem_read  out  1  forwarded control

## Operation
- Accept: in_valid && in_ready.
- in_ready = !hazard && (!out_valid || out_ready).
- hazard = out_valid && out_mem_read && out_reg_write && out_dest != 0 && (out_dest == rs || (uses_rt && out_dest == rt)).
- When the stage accepts inputs, the ID/EX register loads the operands, immediates, dest = reg_dst ? rd : rt, and the control bits, and sets out_valid=1.
- When out_valid && out_ready && !accept: out_valid←0 (bubble). A hazard with out_ready=1 always produces exactly one bubble cycle.
- When out_valid && !out_ready: the ID/EX register holds all fields.
- flush: out_valid←0 at the next edge and has priority over accept. Inputs presented with flush still follow in_ready, and a flushed accept is discarded.
- Register file: register 0 reads 0 and ignores writes. Writes occur at the rising edge when wb_we is high and wb_addr != 0, independent of the stall, flush and accept state.
- Immediate: out_sgn_ext_imm = {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}. out_imm_shl2 = out_sgn_ext_imm << 2, truncated to DATA_W.

## Timing
- Latency is 1 cycle from accept to out_valid.
- The hazard path is combinational from the ID/EX register and rs/rt to in_ready.
- Reset (asynchronous, active-low): all output registers are 0, out_valid=0, and every register-file entry is 0. in_ready is 1 after reset.
- A reset asserted mid-operation drops the in-flight instruction.
- Operand values are frozen at capture. A later WB write to the same register does not update a held ID/EX entry.

## Configuration
- DECODE_BYPASS_EN defined: write-first register file. If wb_we && wb_addr != 0 && wb_addr equals a read address in the accept cycle, that operand captures wb_data.
- DECODE_BYPASS_EN undefined: reads return the pre-edge array contents (read-before-write). Same-cycle RAW through the register file is resolved elsewhere.

## Structure
- Shared package decode_pkg: DATA_W/NREG/IMM_W defaults and a typedef for the ID/EX control bundle (reg_write, mem_read, dest).
- One sub-module, regfile_nr: parametrised 2R1W array with the zero-register rule and the DECODE_BYPASS_EN logic.
- Hazard detection, the immediate unit and the ID/EX register sit in decode_stage.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via WB; next cycle decode rs=5, rt=0, reg_dst=1, rd=9 -> out_rd_data1=0xDEADBEEF, out_rd_data2=0, out_dest=9, out_valid=1 one cycle later.
- imm=0x8004 -> out_sgn_ext_imm=0xFFFF8004, out_imm_shl2=0xFFFE0010, out_imm_raw=0x8004. imm=0x7FFF -> 0x00007FFF.
- Load to r3 in ID/EX, then next instruction has rs=3 with out_ready=1 -> in_ready=0 for one cycle, one bubble (out_valid=0), then accept. With uses_rt=0 and rt=3 -> no stall.
- Same-cycle WB r7=0x12345678 and decode rs=7 -> captured 0x12345678 with DECODE_BYPASS_EN, the old value without it. A WB write to r0 -> a read of r0 returns 0.
- out_ready=0 for 3 cycles -> in_ready=0 and outputs stable. Assert flush -> out_valid=0 next edge. Assert reset mid-stall -> all outputs 0 immediately.
